// File: rtl/sys_array_pkg.sv
// Shared types and constants for the 2x2 systolic array controller.
package sys_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StHold
  } state_e;

  localparam int unsigned NUM_BEATS = 3;
  localparam int unsigned BEAT_W    = 2;

  // Lane order inside a packed 2x2 matrix: [0]=x00, [1]=x01, [2]=x10, [3]=x11.
  localparam int unsigned L00 = 0;
  localparam int unsigned L01 = 1;
  localparam int unsigned L10 = 2;
  localparam int unsigned L11 = 3;

  // Bit offset of a lane within a packed matrix of width-bit elements.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sys_array_skew.sv
// Combinational beat-to-operand selector producing the skewed row/column feed.
module sys_array_skew
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [4*DATA_W-1:0] i_mat_a,
  input  logic [4*DATA_W-1:0] i_mat_b,
  input  logic [BEAT_W-1:0]   i_beat,
  output logic [DATA_W-1:0]   o_row0,
  output logic [DATA_W-1:0]   o_row1,
  output logic [DATA_W-1:0]   o_col0,
  output logic [DATA_W-1:0]   o_col1
);

  logic [DATA_W-1:0] w_a00, w_a01, w_a10, w_a11;
  logic [DATA_W-1:0] w_b00, w_b01, w_b10, w_b11;

  assign w_a00 = i_mat_a[lane_lsb(L00, DATA_W) +: DATA_W];
  assign w_a01 = i_mat_a[lane_lsb(L01, DATA_W) +: DATA_W];
  assign w_a10 = i_mat_a[lane_lsb(L10, DATA_W) +: DATA_W];
  assign w_a11 = i_mat_a[lane_lsb(L11, DATA_W) +: DATA_W];
  assign w_b00 = i_mat_b[lane_lsb(L00, DATA_W) +: DATA_W];
  assign w_b01 = i_mat_b[lane_lsb(L01, DATA_W) +: DATA_W];
  assign w_b10 = i_mat_b[lane_lsb(L10, DATA_W) +: DATA_W];
  assign w_b11 = i_mat_b[lane_lsb(L11, DATA_W) +: DATA_W];

  always_comb begin
    o_row0 = '0;
    o_row1 = '0;
    o_col0 = '0;
    o_col1 = '0;
    case (i_beat)
      2'd0: begin
        o_row0 = w_a00;
        o_col0 = w_b00;
      end
      2'd1: begin
        o_row0 = w_a01;
        o_row1 = w_a10;
        o_col0 = w_b10;
        o_col1 = w_b01;
      end
      2'd2: begin
        o_row1 = w_a11;
        o_col1 = w_b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sys_array_ctrl.sv
// Job sequencer for the 2x2 systolic array: accepts A/B, feeds three skewed beats,
// waits for the array after each beat and holds the captured result for the consumer.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_start_ready,
  input  logic [4*DATA_W-1:0] i_mat_a,
  input  logic [4*DATA_W-1:0] i_mat_b,
  output logic                o_arr_load,
  output logic [DATA_W-1:0]   o_arr_row0,
  output logic [DATA_W-1:0]   o_arr_row1,
  output logic [DATA_W-1:0]   o_arr_col0,
  output logic [DATA_W-1:0]   o_arr_col1,
  input  logic                i_arr_done,
  input  logic [4*DATA_W-1:0] i_arr_res,
  output logic [4*DATA_W-1:0] o_res_mat,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic                o_busy,
  output logic                o_timeout_err,
  output logic [15:0]         o_jobs_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_BEATS - 1);

  state_e              r_state, w_state_d;
  logic [BEAT_W-1:0]   r_beat, w_beat_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [4*DATA_W-1:0] r_mat_a, r_mat_b, w_mat_a_d, w_mat_b_d;
  logic [4*DATA_W-1:0] r_res_mat;
  logic [DATA_W-1:0]   r_row0, r_row1, r_col0, r_col1;
  logic [DATA_W-1:0]   w_row0, w_row1, w_col0, w_col1;
  logic                r_arr_load, r_res_valid, r_timeout_err;
  logic [15:0]         r_jobs_done;
  logic                w_accept, w_capture, w_handoff, w_timeout;

  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_handoff = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_beat_d  = '0;
          w_state_d = StFeed;
        end
      end
      StFeed: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (i_arr_done) begin
          if (r_beat == BEAT_LAST) begin
            w_capture = 1'b1;
            w_state_d = StHold;
          end else begin
            w_beat_d  = r_beat + 1'b1;
            w_state_d = StFeed;
          end
        end else begin
          // Saturating count of WAIT cycles; reaching TIMEOUT abandons the job.
          w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
          if (w_cnt_d == CNT_MAX) begin
            w_timeout = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StHold: begin
        if (i_res_ready) begin
          w_handoff = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_mat_a_d = w_accept ? i_mat_a : r_mat_a;
  assign w_mat_b_d = w_accept ? i_mat_b : r_mat_b;

  // Fed with next-state values so the operands are registered for the FEED cycle.
  sys_array_skew #(
    .DATA_W (DATA_W)
  ) u_skew (
    .i_mat_a (w_mat_a_d),
    .i_mat_b (w_mat_b_d),
    .i_beat  (w_beat_d),
    .o_row0  (w_row0),
    .o_row1  (w_row1),
    .o_col0  (w_col0),
    .o_col1  (w_col1)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_beat        <= '0;
      r_cnt         <= '0;
      r_mat_a       <= '0;
      r_mat_b       <= '0;
      r_res_mat     <= '0;
      r_row0        <= '0;
      r_row1        <= '0;
      r_col0        <= '0;
      r_col1        <= '0;
      r_arr_load    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      r_state       <= w_state_d;
      r_beat        <= w_beat_d;
      r_cnt         <= w_cnt_d;
      r_mat_a       <= w_mat_a_d;
      r_mat_b       <= w_mat_b_d;
      r_arr_load    <= (w_state_d == StFeed);
      r_timeout_err <= w_timeout;
      if (w_state_d == StFeed) begin
        r_row0 <= w_row0;
        r_row1 <= w_row1;
        r_col0 <= w_col0;
        r_col1 <= w_col1;
      end else if (w_state_d != StWait) begin
        r_row0 <= '0;
        r_row1 <= '0;
        r_col0 <= '0;
        r_col1 <= '0;
      end
      if (w_capture) begin
        r_res_mat   <= i_arr_res;
        r_res_valid <= 1'b1;
      end else if (w_handoff) begin
        r_res_valid <= 1'b0;
        r_jobs_done <= r_jobs_done + 16'd1;
      end
    end
  end

  assign o_start_ready = (r_state == StIdle) && !i_rst;
  assign o_busy        = (r_state != StIdle);
  assign o_arr_load    = r_arr_load;
  assign o_arr_row0    = r_row0;
  assign o_arr_row1    = r_row1;
  assign o_arr_col0    = r_col0;
  assign o_arr_col1    = r_col1;
  assign o_res_mat     = r_res_mat;
  assign o_res_valid   = r_res_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_jobs_done   = r_jobs_done;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl with TIMEOUT=4 and hand-driven array responses.
module tb_sys_array_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start_ready;
  logic [127:0] mat_a, mat_b;
  logic         arr_load;
  logic [31:0]  row0, row1, col0, col1;
  logic         arr_done;
  logic [127:0] arr_res;
  logic [127:0] res_mat;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  jobs_done;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [127:0] IDENT_A = 128'h3F800000_00000000_00000000_3F800000;
  localparam logic [127:0] IDENT_B = 128'h40A00000_40800000_40400000_40000000;
  localparam logic [127:0] IDENT_R = 128'h40A00000_40800000_40400000_40000000;
  localparam logic [127:0] HEX_A   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] HEX_B   = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] HEX_R   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  sys_array_ctrl #(
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_start_ready (start_ready),
    .i_mat_a       (mat_a),
    .i_mat_b       (mat_b),
    .o_arr_load    (arr_load),
    .o_arr_row0    (row0),
    .o_arr_row1    (row1),
    .o_arr_col0    (col0),
    .o_arr_col1    (col1),
    .i_arr_done    (arr_done),
    .i_arr_res     (arr_res),
    .o_res_mat     (res_mat),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_busy        (busy),
    .o_timeout_err (timeout_err),
    .o_jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FEED cycle check, then first WAIT cycle with arr_done raised; ends in the next state.
  task automatic do_beat(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] c0, input logic [31:0] c1);
    chk({tag, "_load"}, arr_load, 1'b1);
    chk({tag, "_ops"}, {row0, row1, col0, col1}, {r0, r1, c0, c1});
    tick();
    arr_done = 1'b1;
    chk({tag, "_wload"}, arr_load, 1'b0);
    chk({tag, "_wops"}, {row0, row1, col0, col1}, {r0, r1, c0, c1});
    tick();
    arr_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mat_a     = '0;
    mat_b     = '0;
    arr_done  = 1'b0;
    arr_res   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", start_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load", arr_load, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_jobs", jobs_done, 16'd0);
    chk("rst_res", res_mat, 128'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", start_ready, 1'b1);

    // Identity times B, best-case timing, then consumer back-pressure.
    mat_a   = IDENT_A;
    mat_b   = IDENT_B;
    arr_res = IDENT_R;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("id_busy", busy, 1'b1);
    chk("id_ready", start_ready, 1'b0);
    do_beat("id_b0", 32'h3F800000, 32'h0, 32'h40000000, 32'h0);
    do_beat("id_b1", 32'h0, 32'h0, 32'h40800000, 32'h40400000);
    do_beat("id_b2", 32'h0, 32'h3F800000, 32'h0, 32'h40A00000);
    chk("id_valid_t7", res_valid, 1'b1);
    chk("id_res", res_mat, IDENT_R);
    chk("id_ops_hold0", {row0, row1, col0, col1}, 128'd0);
    for (int i = 0; i < 10; i++) begin
      start    = 1'b1;
      arr_done = i[0];
      arr_res  = ~IDENT_R;
      mat_a    = HEX_A;
      tick();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_res", res_mat, IDENT_R);
      chk("bp_ready", start_ready, 1'b0);
      chk("bp_jobs", jobs_done, 16'd0);
    end
    start     = 1'b0;
    arr_done  = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("bp_rel_valid", res_valid, 1'b0);
    chk("bp_rel_jobs", jobs_done, 16'd1);
    chk("bp_rel_busy", busy, 1'b0);
    tick();
    chk("bp_once_jobs", jobs_done, 16'd1);
    chk("bp_idle", busy, 1'b0);

    // Timeout in WAIT of beat1, then a start in the error cycle.
    mat_a = HEX_A;
    mat_b = HEX_B;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_beat("to_b0", 32'h11111111, 32'h0, 32'h55555555, 32'h0);
    chk("to_b1_load", arr_load, 1'b1);
    chk("to_b1_ops", {row0, row1, col0, col1},
        {32'h22222222, 32'h33333333, 32'h77777777, 32'h66666666});
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_busy", busy, 1'b1);
      chk("to_wait_err", timeout_err, 1'b0);
      tick();
    end
    chk("to_err", timeout_err, 1'b1);
    chk("to_idle", busy, 1'b0);
    chk("to_valid", res_valid, 1'b0);
    chk("to_ops0", {row0, row1, col0, col1}, 128'd0);
    chk("to_ready", start_ready, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_pulse", timeout_err, 1'b0);
    chk("to_restart_busy", busy, 1'b1);

    // Spurious done in FEED and HOLD on the restarted job.
    arr_res  = HEX_R;
    arr_done = 1'b1;
    chk("sp_feed_load", arr_load, 1'b1);
    tick();
    arr_done = 1'b0;
    chk("sp_wait_load", arr_load, 1'b0);
    chk("sp_wait_ops", {row0, row1, col0, col1}, {32'h11111111, 32'h0, 32'h55555555, 32'h0});
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    do_beat("sp_b1", 32'h22222222, 32'h33333333, 32'h77777777, 32'h66666666);
    do_beat("sp_b2", 32'h0, 32'h44444444, 32'h0, 32'h88888888);
    chk("sp_valid", res_valid, 1'b1);
    chk("sp_res", res_mat, HEX_R);
    res_ready = 1'b0;
    arr_done  = 1'b1;
    arr_res   = IDENT_R;
    tick();
    arr_done = 1'b0;
    chk("sp_hold_res", res_mat, HEX_R);
    chk("sp_hold_valid", res_valid, 1'b1);
    chk("sp_hold_busy", busy, 1'b1);
    force dut.r_jobs_done = 16'hFFFF;
    #1;
    release dut.r_jobs_done;
    chk("wrap_pre", jobs_done, 16'hFFFF);
    res_ready = 1'b1;
    tick();
    chk("wrap_post", jobs_done, 16'd0);
    chk("wrap_valid", res_valid, 1'b0);

    // Three back-to-back jobs, accepts 8 cycles apart.
    arr_res = IDENT_R;
    start   = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("tp_ready", start_ready, 1'b1);
      tick();
      do_beat("tp_b0", 32'h11111111, 32'h0, 32'h55555555, 32'h0);
      do_beat("tp_b1", 32'h22222222, 32'h33333333, 32'h77777777, 32'h66666666);
      do_beat("tp_b2", 32'h0, 32'h44444444, 32'h0, 32'h88888888);
      chk("tp_valid", res_valid, 1'b1);
      chk("tp_res", res_mat, IDENT_R);
      if (j == 2) start = 1'b0;
      tick();
    end
    chk("tp_jobs", jobs_done, 16'd3);
    chk("tp_idle", busy, 1'b0);

    // Reset during WAIT of beat1.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    tick();
    chk("mr_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", start_ready, 1'b0);
    chk("mr_ops", {row0, row1, col0, col1}, 128'd0);
    chk("mr_load", arr_load, 1'b0);
    chk("mr_jobs", jobs_done, 16'd0);
    chk("mr_valid", res_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_rel_ready", start_ready, 1'b1);
    tick();
    chk("mr_rel_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
